// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity checking
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam logic PAR_EN = 1'b0;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic par_bad_q, par_bad_d;
  logic rx_valid_q, rx_valid_d;
  logic frame_err_q, frame_err_d;
  logic parity_err_q, parity_err_d;
  logic overrun_q, overrun_d;
  logic rx_s, sample;
  assign rx_s = sync_q[1];
  assign sample = baud_q == FULL;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy = state_q != IDLE;
  assign frame_err = frame_err_q;
  assign parity_err = PAR_EN & parity_err_q;
  assign overrun = overrun_q;
  // two-flop synchronizer for the asynchronous serial line, idling high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], rx};
  end
  // next-state, sampling and delivery decisions; baud counter restarts on every state entry and each bit
  always_comb begin
    state_d = state_q;
    baud_d = (state_q == IDLE) ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    par_bad_d = par_bad_q;
    rx_data_d = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    frame_err_d = 1'b0;
    parity_err_d = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) state_d = START;
      START: begin
        bit_d = '0;
        par_bad_d = 1'b0;
        if (baud_q == HALF) state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (sample) begin
        shift_d = {rx_s, shift_q[7:1]};
        bit_d = bit_q + 1'b1;
        state_d = (bit_q == 3'd7) ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (sample) begin
        par_bad_d = rx_s ^ (^shift_q);
        state_d = STOP;
      end
`endif
      STOP: if (sample) begin
        parity_err_d = par_bad_q;
        frame_err_d = ~rx_s;
        state_d = rx_s ? IDLE : WAIT_IDLE;
        if (rx_s && !par_bad_q) begin
          overrun_d = rx_valid_q & ~rx_ready;
          rx_data_d = overrun_d ? rx_data_q : shift_q;
          rx_valid_d = 1'b1;
        end
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q || sample) baud_d = '0;
  end
  // state register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_bad_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_bad_q <= par_bad_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frame_err_q <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed and randomized frame checks of uart_rx_os against a frame-level model
module tb_uart_rx_os;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, busy, frame_err, parity_err, overrun;
  int cyc = 0, passed = 0, total = 0;
  int n_vc = 0, n_fe = 0, n_pe = 0, n_ov = 0, rise_cyc = -1;
  int b_vc, b_fe, b_pe, b_ov;
  logic prev_v = 1'b0;
  logic [7:0] acc_q[$];

  uart_rx_os #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_v <= rx_valid;
    if (rx_valid && !prev_v) rise_cyc <= cyc;
    if (rx_valid) n_vc <= n_vc + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (parity_err) n_pe <= n_pe + 1;
    if (overrun) n_ov <= n_ov + 1;
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic snap();
    b_vc = n_vc;
    b_fe = n_fe;
    b_pe = n_pe;
    b_ov = n_ov;
  endtask

  function automatic logic [31:0] pop_acc();
    return (acc_q.size() > 0) ? {24'd0, acc_q.pop_front()} : 32'hdead;
  endfunction

  // drives one full frame and leaves the line at the stop-bit level
  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b, output int p);
    logic [10:0] f;
    int nb;
    f = PAR ? {stop_b, par_b, d, 1'b0} : {1'b1, stop_b, d, 1'b0};
    nb = PAR ? 11 : 10;
    p = cyc;
    for (int i = 0; i < nb; i++) begin
      rx = f[i];
      tick(C);
    end
  endtask

  initial begin
    int p, efe, epe;
    logic [7:0] d;
    logic sb, pok;
    logic [7:0] exp_q[$];
    tick(3);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_pe", parity_err, 0);
    chk("rst_ov", overrun, 0);
    rst_n = 1'b1;
    tick(4);

    snap();
    send(8'hA5, 1'b1, 1'b0, p);
    idle(2 * C);
    chk("a5_latency", rise_cyc, p + 155);
    chk("a5_valid_cycles", n_vc - b_vc, 1);
    chk("a5_data", pop_acc(), 8'hA5);
    chk("a5_errs", (n_fe - b_fe) + (n_pe - b_pe) + (n_ov - b_ov), 0);

    snap();
    rx = 1'b0;
    tick(5);
    chk("fs_busy_during", busy, 1);
    idle(2 * C);
    chk("fs_busy_after", busy, 0);
    chk("fs_no_valid", n_vc - b_vc, 0);
    chk("fs_no_pulses", (n_fe - b_fe) + (n_pe - b_pe) + (n_ov - b_ov), 0);

    snap();
    send(8'h3C, 1'b0, 1'b0, p);
    chk("fe_busy_low", busy, 1);
    idle(4);
    chk("fe_busy_idle", busy, 0);
    chk("fe_count", n_fe - b_fe, 1);
    chk("fe_no_valid", n_vc - b_vc, 0);
    chk("fe_no_ov", n_ov - b_ov, 0);

    rx_ready = 1'b0;
    snap();
    send(8'h11, 1'b1, 1'b0, p);
    idle(C);
    send(8'h22, 1'b1, 1'b0, p);
    idle(C);
    chk("ov_valid", rx_valid, 1);
    chk("ov_data", rx_data, 8'h11);
    chk("ov_count", n_ov - b_ov, 1);
    rx_ready = 1'b1;
    tick(1);
    chk("ov_valid_after", rx_valid, 0);
    chk("ov_accepted", pop_acc(), 8'h11);
    chk("ov_acc_empty", acc_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    snap();
    send(8'h07, 1'b1, 1'b0, p);
    idle(2 * C);
    chk("par_bad_pe", n_pe - b_pe, 1);
    chk("par_bad_no_valid", n_vc - b_vc, 0);
    send(8'h07, 1'b1, 1'b1, p);
    idle(2 * C);
    chk("par_ok_data", pop_acc(), 8'h07);
    chk("par_ok_pe", n_pe - b_pe, 1);
`endif

    snap();
    d = 8'hC3;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(C);
    end
    rx = d[4];
    tick(C / 2);
    chk("rst_mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", rx_data, 0);
    chk("rst_mid_outs", {rx_valid, busy, frame_err, parity_err, overrun}, 0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    send(8'h5A, 1'b1, 1'b0, p);
    idle(2 * C);
    chk("rst_mid_5a", pop_acc(), 8'h5A);
    chk("rst_mid_no_pulses", (n_fe - b_fe) + (n_pe - b_pe) + (n_ov - b_ov), 0);

    snap();
    efe = 0;
    epe = 0;
    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom);
      sb = ($urandom_range(3) != 0);
      pok = PAR ? ($urandom_range(3) != 0) : 1'b1;
      send(d, sb, (^d) ^ ~pok, p);
      idle(C + $urandom_range(8));
      if (!sb) efe++;
      if (!pok) epe++;
      if (sb && pok) exp_q.push_back(d);
    end
    chk("rnd_fe", n_fe - b_fe, efe);
    chk("rnd_pe", n_pe - b_pe, epe);
    chk("rnd_ov", n_ov - b_ov, 0);
    chk("rnd_count", acc_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) chk("rnd_byte", pop_acc(), {24'd0, exp_q[k]});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
